// File: rtl/r16_pkg.sv
// rtl/r16_pkg.sv - shared constants and address-FIFO entry type for the radix-16 write-back path
package r16_pkg;

  localparam int A_WIDTH     = 11;
  localparam int D_WIDTH     = 64;
  localparam int FIFO_DEPTH  = 64;
  localparam int PTS_PER_STG = 4096;
  localparam int NUM_STG     = 4;

  localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W   = $clog2(PTS_PER_STG);
  localparam int STG_W   = $clog2(NUM_STG);
  localparam int ENTRY_W = A_WIDTH + 1;

  typedef struct packed {
    logic               bn;
    logic [A_WIDTH-1:0] ma;
  } wb_entry_t;

endpackage

// File: rtl/r16_addr_fifo.sv
// rtl/r16_addr_fifo.sv - synchronous FIFO holding read {bank, address} pairs until their PE results return
module r16_addr_fifo
  import r16_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-2:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/r16_wb_addr_seq.sv
// rtl/r16_wb_addr_seq.sv - replays captured read bank/address pairs as write strobes for PE results
module r16_wb_addr_seq
  import r16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_valid,
  input  logic               rd_bn,
  input  logic [A_WIDTH-1:0] rd_ma,
  input  logic               pe_valid,
  input  logic [D_WIDTH-1:0] pe_data,
  output logic               bank0_we,
  output logic               bank1_we,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0] wr_data,
  output logic               stage_done,
  output logic               fft_done,
  output logic [STG_W-1:0]   stage_idx,
  output logic [PTR_W-1:0]   fifo_level,
  output logic               ovf_err,
  output logic               unf_err
);

  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             full;
  logic             empty;
  logic             do_pop;
  logic             last_pt;
  logic [CNT_W-1:0] wr_cnt;

  assign push_entry = '{bn: rd_bn, ma: rd_ma};
  assign do_pop     = pe_valid && !empty;
  assign last_pt    = (wr_cnt == CNT_W'(PTS_PER_STG - 1));

  r16_addr_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rd_valid),
    .pop  (pe_valid),
    .wdata(push_entry),
    .rdata(head),
    .level(fifo_level),
    .full (full),
    .empty(empty)
  );

  // Counters advance at the pop so stage_done lines up with the registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_we   <= 1'b0;
      bank1_we   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      stage_done <= 1'b0;
      fft_done   <= 1'b0;
      stage_idx  <= '0;
      wr_cnt     <= '0;
      ovf_err    <= 1'b0;
      unf_err    <= 1'b0;
    end else begin
      bank0_we   <= do_pop && !head.bn;
      bank1_we   <= do_pop && head.bn;
      stage_done <= do_pop && last_pt;
      fft_done   <= do_pop && last_pt && (stage_idx == STG_W'(NUM_STG - 1));
      if (do_pop) begin
        wr_addr <= head.ma;
        wr_data <= pe_data;
        if (last_pt) begin
          wr_cnt    <= '0;
          stage_idx <= (stage_idx == STG_W'(NUM_STG - 1)) ? '0 : stage_idx + 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_valid && full && !pe_valid) ovf_err <= 1'b1;
      if (pe_valid && empty)             unf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_r16_wb_addr_seq.sv
// tb/tb_r16_wb_addr_seq.sv - directed self-checking bench for the write-back address sequencer
module tb_r16_wb_addr_seq;

  logic        clk;
  logic        rst_n;
  logic        rd_valid;
  logic        rd_bn;
  logic [10:0] rd_ma;
  logic        pe_valid;
  logic [63:0] pe_data;
  logic        bank0_we;
  logic        bank1_we;
  logic [10:0] wr_addr;
  logic [63:0] wr_data;
  logic        stage_done;
  logic        fft_done;
  logic [1:0]  stage_idx;
  logic [6:0]  fifo_level;
  logic        ovf_err;
  logic        unf_err;

  logic [76:0] wv;
  logic [89:0] all_outs;

  int total = 0;
  int bad   = 0;

  r16_wb_addr_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_valid  (rd_valid),
    .rd_bn     (rd_bn),
    .rd_ma     (rd_ma),
    .pe_valid  (pe_valid),
    .pe_data   (pe_data),
    .bank0_we  (bank0_we),
    .bank1_we  (bank1_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .stage_done(stage_done),
    .fft_done  (fft_done),
    .stage_idx (stage_idx),
    .fifo_level(fifo_level),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  assign wv       = {bank0_we, bank1_we, wr_addr, wr_data};
  assign all_outs = {bank0_we, bank1_we, wr_addr, wr_data, stage_done, fft_done,
                     stage_idx, fifo_level, ovf_err, unf_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ebn(input int j);
    return j[0] ^ j[4];
  endfunction

  function automatic logic [10:0] ema(input int j);
    return 11'(j * 13 + 5);
  endfunction

  function automatic logic [63:0] edat(input int j);
    return {32'(j), 32'hC0DE0000 ^ 32'(j * 3)};
  endfunction

  task automatic idle_inputs();
    rd_valid = 1'b0;
    rd_bn    = 1'b0;
    rd_ma    = '0;
    pe_valid = 1'b0;
    pe_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int j;
    int exp_lvl;
    int sd_cnt;
    int fd_cnt;

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk("reset_outputs", all_outs, 0);
    tick();
    rst_n = 1'b1;
    chk("reset_outputs_after_clk", all_outs, 0);

    // Three captured reads replayed after PE latency
    rd_valid = 1'b1; rd_bn = 1'b0; rd_ma = 11'd5;
    tick();
    rd_bn = 1'b1; rd_ma = 11'd5;
    tick();
    rd_bn = 1'b1; rd_ma = 11'h7FF;
    tick();
    idle_inputs();
    chk("t1_level_after_push", fifo_level, 3);
    repeat (48) tick();
    chk("t1_level_after_idle", fifo_level, 3);
    chk("t1_no_strobe_idle", {bank0_we, bank1_we}, 0);
    pe_valid = 1'b1; pe_data = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    chk("t1_write_a", wv, {1'b1, 1'b0, 11'd5, 64'hAAAA_AAAA_AAAA_AAAA});
    chk("t1_level_2", fifo_level, 2);
    pe_data = 64'hBBBB_BBBB_BBBB_BBBB;
    tick();
    chk("t1_write_b", wv, {1'b0, 1'b1, 11'd5, 64'hBBBB_BBBB_BBBB_BBBB});
    pe_data = 64'hCCCC_CCCC_CCCC_CCCC;
    tick();
    chk("t1_write_c", wv, {1'b0, 1'b1, 11'h7FF, 64'hCCCC_CCCC_CCCC_CCCC});
    chk("t1_level_0", fifo_level, 0);
    idle_inputs();
    tick();
    chk("t1_idle_hold", wv, {1'b0, 1'b0, 11'h7FF, 64'hCCCC_CCCC_CCCC_CCCC});

    // Underflow on an empty FIFO
    do_reset();
    pe_valid = 1'b1; pe_data = 64'h1234;
    tick();
    idle_inputs();
    chk("t5_no_strobe", {bank0_we, bank1_we}, 0);
    chk("t5_unf_err", unf_err, 1);
    chk("t5_level", fifo_level, 0);
    chk("t5_no_stage_done", stage_done, 0);

    // Four full stages of streamed traffic, pops lagging pushes by 48 cycles
    n = 4 * 4096;
    exp_lvl = 0;
    sd_cnt = 0;
    fd_cnt = 0;
    for (int c = 0; c < n + 48; c++) begin
      j = c - 48;
      rd_valid = (c < n);
      rd_bn    = ebn(c);
      rd_ma    = ema(c);
      pe_valid = (c >= 48);
      pe_data  = pe_valid ? edat(j) : 64'd0;
      tick();
      if (rd_valid) exp_lvl++;
      if (pe_valid) exp_lvl--;
      chk("stream_level", fifo_level, exp_lvl);
      if (pe_valid) begin
        chk("stream_write", wv, {~ebn(j), ebn(j), ema(j), edat(j)});
        chk("stream_stage_done", stage_done, (j % 4096) == 4095);
        chk("stream_fft_done", fft_done, j == n - 1);
        chk("stream_stage_idx", stage_idx, ((j + 1) / 4096) % 4);
      end else begin
        chk("stream_idle_strobe", {bank0_we, bank1_we}, 0);
      end
      sd_cnt += int'(stage_done);
      fd_cnt += int'(fft_done);
      if (pe_valid && j == 4095) begin
        chk("t2_stage_done_once", sd_cnt, 1);
        chk("t2_stage_idx_1", stage_idx, 1);
        chk("t2_no_ovf", ovf_err, 0);
      end
    end
    idle_inputs();
    tick();
    chk("t3_stage_done_count", sd_cnt, 4);
    chk("t3_fft_done_count", fd_cnt, 1);
    chk("t3_stage_idx_wrap", stage_idx, 0);
    chk("t3_no_ovf", ovf_err, 0);
    chk("t3_unf_sticky", unf_err, 1);
    chk("t3_level_empty", fifo_level, 0);

    // Full FIFO: push+pop is legal, push alone drops the entry
    do_reset();
    for (int i = 0; i < 64; i++) begin
      rd_valid = 1'b1; rd_bn = 1'b0; rd_ma = 11'(i);
      tick();
    end
    chk("t4_level_full", fifo_level, 64);
    rd_valid = 1'b1; rd_bn = 1'b1; rd_ma = 11'd100;
    pe_valid = 1'b1; pe_data = 64'hF00D;
    tick();
    chk("t4_pushpop_level", fifo_level, 64);
    chk("t4_pushpop_no_ovf", ovf_err, 0);
    chk("t4_pushpop_write", wv, {1'b1, 1'b0, 11'd0, 64'hF00D});
    pe_valid = 1'b0; rd_ma = 11'h555;
    tick();
    rd_valid = 1'b0;
    chk("t4_ovf_err", ovf_err, 1);
    chk("t4_ovf_level", fifo_level, 64);
    chk("t4_ovf_no_strobe", {bank0_we, bank1_we}, 0);
    for (int i = 1; i < 64; i++) begin
      pe_valid = 1'b1; pe_data = 64'h100 + 64'(i);
      tick();
      chk("t4_drain", wv, {1'b1, 1'b0, 11'(i), 64'h100 + 64'(i)});
    end
    pe_data = 64'hBEEF;
    tick();
    chk("t4_drain_last", wv, {1'b0, 1'b1, 11'd100, 64'hBEEF});
    chk("t4_drained_level", fifo_level, 0);
    tick();
    idle_inputs();
    chk("t4_dropped_never_written", {bank0_we, bank1_we}, 0);
    chk("t4_unf_after_drain", unf_err, 1);

    // Asynchronous reset mid-stage
    do_reset();
    for (int i = 0; i < 25; i++) begin
      rd_valid = 1'b1; rd_bn = 1'(i); rd_ma = 11'(12'h40 + i);
      tick();
    end
    rd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pe_valid = 1'b1; pe_data = 64'hDEAD_0000 + 64'(i);
      tick();
    end
    pe_valid = 1'b0;
    chk("t6_level_20", fifo_level, 20);
    chk("t6_last_write", wv, {1'b1, 1'b0, 11'h44, 64'hDEAD_0004});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset_outs", all_outs, 0);
    tick();
    rst_n = 1'b1;
    chk("t6_level_after_reset", fifo_level, 0);
    rd_valid = 1'b1; rd_bn = 1'b1; rd_ma = 11'h123;
    tick();
    rd_valid = 1'b0;
    pe_valid = 1'b1; pe_data = 64'h5A5A_5A5A;
    tick();
    idle_inputs();
    chk("t6_fresh_write", wv, {1'b0, 1'b1, 11'h123, 64'h5A5A_5A5A});
    chk("t6_stage_idx", stage_idx, 0);
    chk("t6_level_end", fifo_level, 0);
    chk("t6_errs_clear", {ovf_err, unf_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
